// File: rtl/reset_request_gen.sv
// reset_request_gen: source end of the core reset path. Collects power-on, debounced
// push-button, software and watchdog reset requests, stretches each accepted request into a
// fixed-width reset_req pulse followed by a hold-off window, and records the cause.
module reset_request_gen #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned PULSE_CYCLES    = 8,
   parameter int unsigned HOLDOFF_CYCLES  = 4,
   parameter int unsigned WDT_WIDTH       = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 btn_in,
   input  logic                 sw_req,
   input  logic                 wdt_en,
   input  logic [WDT_WIDTH-1:0] wdt_load,
   input  logic                 wdt_kick,
   input  logic                 cause_clr,
   output logic                 reset_req,
   output logic [2:0]           cause,
   output logic                 busy
);

   // Debounce counter only has to reach DEBOUNCE_CYCLES-1.
   localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);
   // One counter is shared by the pulse and hold-off phases.
   localparam int unsigned CntMax = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES :
                                                                      HOLDOFF_CYCLES;
   localparam int unsigned CntW = (CntMax > 1) ? $clog2(CntMax) : 1;

   localparam logic [DbW-1:0]       DbLast    = DbW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DbW-1:0]       DbOne     = DbW'(1);
   localparam logic [CntW-1:0]      PulseLast = CntW'(PULSE_CYCLES - 1);
   localparam logic [CntW-1:0]      HoldLast  = CntW'(HOLDOFF_CYCLES - 1);
   localparam logic [CntW-1:0]      CntOne    = CntW'(1);
   localparam logic [WDT_WIDTH-1:0] WdtOne    = WDT_WIDTH'(1);

   typedef enum logic [1:0] {
      StIdle,
      StAssert,
      StHoldoff
   } state_e;

   // Button path
   logic           sync1_q, sync2_q;
   logic [DbW-1:0] db_cnt_q, db_cnt_d;
   logic           db_level_q, db_level_d;
   logic           btn_evt_q, btn_evt_d;

   // Watchdog
   logic [WDT_WIDTH-1:0] wdt_cnt_q, wdt_cnt_d;
   logic                 wdt_evt_q, wdt_evt_d;

   // Sequencer
   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      cause_q, cause_d;
   logic            reset_req_q, busy_q;
   logic [2:0]      evt;

   assign evt = {wdt_evt_q, sw_req, btn_evt_q};

   // Debounce: level follows the synced pin only after DEBOUNCE_CYCLES differing samples.
   always_comb begin
      db_cnt_d   = db_cnt_q;
      db_level_d = db_level_q;
      if (sync2_q == db_level_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DbLast) begin
         db_cnt_d   = '0;
         db_level_d = sync2_q;
      end else begin
         db_cnt_d = db_cnt_q + DbOne;
      end
      // Only a press produces an event; release is tracked silently.
      btn_evt_d = db_level_d & ~db_level_q;
   end

   // Synchroniser, debounce state and registered button event.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         db_cnt_q   <= '0;
         db_level_q <= 1'b0;
         btn_evt_q  <= 1'b0;
      end else begin
         sync1_q    <= btn_in;
         sync2_q    <= sync1_q;
         db_cnt_q   <= db_cnt_d;
         db_level_q <= db_level_d;
         btn_evt_q  <= btn_evt_d;
      end
   end

   // Watchdog: reload when disabled, kicked or sequencer busy; otherwise count down.
   always_comb begin
      wdt_cnt_d = wdt_cnt_q - WdtOne;
      wdt_evt_d = 1'b0;
      if (!wdt_en || wdt_kick || (state_q != StIdle)) begin
         wdt_cnt_d = wdt_load;
      end else if (wdt_cnt_q == WdtOne) begin
         wdt_cnt_d = wdt_load;
         wdt_evt_d = (wdt_load != '0);
      end
   end

   // Watchdog counter and registered expiry event. The counter leaves reset with the
   // sequencer in StAssert, so it is reloaded from wdt_load on the first clock anyway.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wdt_cnt_q <= '0;
         wdt_evt_q <= 1'b0;
      end else begin
         wdt_cnt_q <= wdt_cnt_d;
         wdt_evt_q <= wdt_evt_d;
      end
   end

   // Sequencer next state, phase counter and cause capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cause_d = cause_q;
      case (state_q)
         StIdle: begin
            if (evt != 3'b000) begin
               state_d = StAssert;
               cnt_d   = '0;
            end
         end
         StAssert: begin
            if (cnt_q == PulseLast) begin
               state_d = StHoldoff;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         StHoldoff: begin
            if (cnt_q == HoldLast) begin
               state_d = StIdle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
         end
      endcase
      // A capture beats a simultaneous clear.
      if ((state_q == StIdle) && (evt != 3'b000)) begin
         cause_d = evt;
      end else if (cause_clr) begin
         cause_d = 3'b000;
      end
   end

   // Sequencer state and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StAssert;
         cnt_q       <= '0;
         cause_q     <= 3'b000;
         reset_req_q <= 1'b1;
         busy_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cause_q     <= cause_d;
         reset_req_q <= (state_d == StAssert);
         busy_q      <= (state_d != StIdle);
      end
   end

   assign reset_req = reset_req_q;
   assign busy      = busy_q;
   assign cause     = cause_q;

endmodule

// File: tb/tb_reset_request_gen.sv
// Bench for reset_request_gen: directed scenarios plus a randomized run, all checked against
// a timestamp-based reference model of the request/pulse/hold-off behaviour.
module tb_reset_request_gen;

   localparam int P    = 8;
   localparam int H    = 4;
   localparam int D    = 16;
   localparam int W    = 16;
   localparam int MAXC = 16384;

   logic         clk       = 1'b0;
   logic         reset_n   = 1'b1;
   logic         btn_in    = 1'b0;
   logic         sw_req    = 1'b0;
   logic         wdt_en    = 1'b0;
   logic [W-1:0] wdt_load  = '0;
   logic         wdt_kick  = 1'b0;
   logic         cause_clr = 1'b0;
   logic         reset_req;
   logic [2:0]   cause;
   logic         busy;

   always #5 clk = ~clk;

   reset_request_gen #(
      .DEBOUNCE_CYCLES (D),
      .PULSE_CYCLES    (P),
      .HOLDOFF_CYCLES  (H),
      .WDT_WIDTH       (W)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .btn_in    (btn_in),
      .sw_req    (sw_req),
      .wdt_en    (wdt_en),
      .wdt_load  (wdt_load),
      .wdt_kick  (wdt_kick),
      .cause_clr (cause_clr),
      .reset_req (reset_req),
      .cause     (cause),
      .busy      (busy)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state. trig = cycle in which the last accepted request was seen;
   // the pulse occupies trig+1..trig+P and the sequencer is busy through trig+P+H.
   int         cyc       = 0;
   int         trig      = -100;
   int         rel       = 0;    // first cycle after reset release
   int         rld       = 0;    // last cycle at whose end the watchdog was reloaded
   bit         in_reset  = 1'b1;
   bit         lvl       = 1'b0; // debounced button level
   bit         bevt      = 1'b0; // button event visible in the current cycle
   bit         wevt      = 1'b0; // watchdog event visible in the current cycle
   logic [2:0] cause_exp = 3'b000;
   bit         pin_hist [MAXC];

   function automatic logic [4:0] exp_out();
      if (in_reset) return 5'b11000;
      return {(cyc > trig) && (cyc <= trig + P), (cyc > trig) && (cyc <= trig + P + H),
              cause_exp};
   endfunction

   function automatic void release_model();
      in_reset  = 1'b0;
      rel       = cyc;
      trig      = cyc - 1;
      rld       = cyc;
      lvl       = 1'b0;
      bevt      = 1'b0;
      wevt      = 1'b0;
      cause_exp = 3'b000;
   endfunction

   // Advance the model over the current cycle using the inputs applied in it.
   function automatic void model_step();
      bit         idle;
      bit         all_diff;
      bit         s;
      logic [2:0] ev;
      idle = (cyc > trig + P + H);
      ev   = {wevt, sw_req, bevt};
      if (idle && (ev != 3'b000)) begin
         trig      = cyc;
         cause_exp = ev;
      end else if (cause_clr) begin
         cause_exp = 3'b000;
      end
      // Button: the synchronised sample in cycle k is the pin two cycles earlier; the
      // debounced level flips once the last D samples all disagree with it.
      if (cyc < MAXC) pin_hist[cyc] = btn_in;
      all_diff = (cyc - (D - 1) >= rel);
      if (all_diff) begin
         for (int k = cyc - (D - 1); k <= cyc; k++) begin
            s = 1'b0;
            if (k - 2 >= rel) s = pin_hist[k - 2];
            if (s == lvl) all_diff = 1'b0;
         end
      end
      bevt = 1'b0;
      if (all_diff) begin
         lvl  = ~lvl;
         bevt = lvl;
      end
      // Watchdog: fires wdt_load cycles after the last reload unless something reloads it.
      wevt = 1'b0;
      if (!wdt_en || wdt_kick || !idle) begin
         rld = cyc;
      end else if ((wdt_load != '0) && (cyc - rld == int'(wdt_load))) begin
         wevt = 1'b1;
         rld  = cyc;
      end
   endfunction

   task automatic tick();
      if (!in_reset) model_step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      int hi;
      #2;
      reset_n  = 1'b0;
      in_reset = 1'b1;
      #1;
      n_cmp++;
      if ({reset_req, busy, cause} !== 5'b11000) begin
         n_bad++;
         $display("FAIL por_async got=%b exp=%b", {reset_req, busy, cause}, 5'b11000);
      end
      repeat (3) begin
         tick();
         n_cmp++;
         if ({reset_req, busy, cause} !== exp_out()) begin
            n_bad++;
            $display("FAIL por_hold cyc=%0d got=%b exp=%b", cyc, {reset_req, busy, cause},
                     exp_out());
         end
      end
      reset_n = 1'b1;
      release_model();
      hi = 0;
      for (int i = 0; i < P + H + 4; i++) begin
         n_cmp++;
         if ({reset_req, busy, cause} !== exp_out()) begin
            n_bad++;
            $display("FAIL por_seq cyc=%0d got=%b exp=%b", cyc, {reset_req, busy, cause},
                     exp_out());
         end
         hi += int'(reset_req);
         tick();
      end
      n_cmp++;
      if (hi != P) begin
         n_bad++;
         $display("FAIL por_width got=%0d exp=%0d", hi, P);
      end
      n_cmp++;
      if ({busy, cause} !== 4'b0000) begin
         n_bad++;
         $display("FAIL por_idle got=%b exp=%b", {busy, cause}, 4'b0000);
      end
   endtask

   task automatic test_sw();
      int   t0;
      int   hi;
      logic busy13;
      t0     = cyc;
      hi     = 0;
      busy13 = 1'bx;
      sw_req = 1'b1;
      for (int i = 0; i < 16; i++) begin
         // Second request lands in the hold-off window and must be dropped.
         if (cyc == t0 + 10) sw_req = 1'b1;
         tick();
         sw_req = 1'b0;
         n_cmp++;
         if ({reset_req, busy, cause} !== exp_out()) begin
            n_bad++;
            $display("FAIL sw_seq cyc=%0d got=%b exp=%b", cyc, {reset_req, busy, cause},
                     exp_out());
         end
         hi += int'(reset_req);
         if (cyc == t0 + 13) busy13 = busy;
      end
      n_cmp++;
      if (hi != P) begin
         n_bad++;
         $display("FAIL sw_width got=%0d exp=%0d", hi, P);
      end
      n_cmp++;
      if (busy13 !== 1'b0) begin
         n_bad++;
         $display("FAIL sw_busy_end got=%b exp=0", busy13);
      end
      n_cmp++;
      if (cause !== 3'b010) begin
         n_bad++;
         $display("FAIL sw_cause got=%b exp=010", cause);
      end
   endtask

   task automatic test_btn_glitch();
      int hi;
      hi     = 0;
      btn_in = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (i == 10) btn_in = 1'b0;
         tick();
         n_cmp++;
         if ({reset_req, busy, cause} !== exp_out()) begin
            n_bad++;
            $display("FAIL glitch_seq cyc=%0d got=%b exp=%b", cyc, {reset_req, busy, cause},
                     exp_out());
         end
         hi += int'(reset_req);
      end
      n_cmp++;
      if (hi != 0) begin
         n_bad++;
         $display("FAIL glitch_pulse got=%0d exp=0", hi);
      end
   endtask

   task automatic test_btn_hold();
      int p;
      int start;
      int hi;
      p      = cyc;
      start  = -1;
      hi     = 0;
      btn_in = 1'b1;
      for (int i = 0; i < 70; i++) begin
         if (i == 40) btn_in = 1'b0;
         tick();
         n_cmp++;
         if ({reset_req, busy, cause} !== exp_out()) begin
            n_bad++;
            $display("FAIL hold_seq cyc=%0d got=%b exp=%b", cyc, {reset_req, busy, cause},
                     exp_out());
         end
         if (reset_req && (start < 0)) start = cyc;
         hi += int'(reset_req);
      end
      n_cmp++;
      if (start - p != 2 + D + 1) begin
         n_bad++;
         $display("FAIL hold_latency got=%0d exp=%0d", start - p, 2 + D + 1);
      end
      n_cmp++;
      if (hi != P) begin
         n_bad++;
         $display("FAIL hold_width got=%0d exp=%0d", hi, P);
      end
      n_cmp++;
      if (cause !== 3'b001) begin
         n_bad++;
         $display("FAIL hold_cause got=%b exp=001", cause);
      end
   endtask

   task automatic test_wdt();
      int e;
      int start;
      int hi;
      wdt_load = W'(5);
      wdt_en   = 1'b0;
      tick();
      e      = cyc;
      start  = -1;
      wdt_en = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         n_cmp++;
         if ({reset_req, busy, cause} !== exp_out()) begin
            n_bad++;
            $display("FAIL wdt_seq cyc=%0d got=%b exp=%b", cyc, {reset_req, busy, cause},
                     exp_out());
         end
         if (reset_req && (start < 0)) begin
            start  = cyc;
            wdt_en = 1'b0;
         end
      end
      n_cmp++;
      if (start - e != 6) begin
         n_bad++;
         $display("FAIL wdt_latency got=%0d exp=6", start - e);
      end
      n_cmp++;
      if (cause !== 3'b100) begin
         n_bad++;
         $display("FAIL wdt_cause got=%b exp=100", cause);
      end
      hi     = 0;
      wdt_en = 1'b1;
      for (int i = 0; i < 60; i++) begin
         wdt_kick = ((i % 3) == 2);
         tick();
         n_cmp++;
         if ({reset_req, busy, cause} !== exp_out()) begin
            n_bad++;
            $display("FAIL kick_seq cyc=%0d got=%b exp=%b", cyc, {reset_req, busy, cause},
                     exp_out());
         end
         hi += int'(reset_req);
      end
      wdt_kick = 1'b0;
      wdt_en   = 1'b0;
      n_cmp++;
      if (hi != 0) begin
         n_bad++;
         $display("FAIL kick_pulse got=%0d exp=0", hi);
      end
   endtask

   task automatic test_sw_wdt_same();
      int hi;
      wdt_load = W'(5);
      wdt_en   = 1'b0;
      tick();
      wdt_en = 1'b1;
      hi     = 0;
      for (int i = 0; i < 22; i++) begin
         // Expiry event is visible five cycles after enable; pair sw_req with it.
         sw_req = (i == 5);
         if (i == 6) wdt_en = 1'b0;
         tick();
         n_cmp++;
         if ({reset_req, busy, cause} !== exp_out()) begin
            n_bad++;
            $display("FAIL both_seq cyc=%0d got=%b exp=%b", cyc, {reset_req, busy, cause},
                     exp_out());
         end
         hi += int'(reset_req);
      end
      sw_req = 1'b0;
      n_cmp++;
      if (hi != P) begin
         n_bad++;
         $display("FAIL both_width got=%0d exp=%0d", hi, P);
      end
      n_cmp++;
      if (cause !== 3'b110) begin
         n_bad++;
         $display("FAIL both_cause got=%b exp=110", cause);
      end
   endtask

   task automatic test_cause_clr();
      cause_clr = 1'b1;
      tick();
      cause_clr = 1'b0;
      n_cmp++;
      if (cause !== 3'b000) begin
         n_bad++;
         $display("FAIL clr_only got=%b exp=000", cause);
      end
      sw_req    = 1'b1;
      cause_clr = 1'b1;
      for (int i = 0; i < 14; i++) begin
         tick();
         sw_req    = 1'b0;
         cause_clr = 1'b0;
         n_cmp++;
         if ({reset_req, busy, cause} !== exp_out()) begin
            n_bad++;
            $display("FAIL clr_seq cyc=%0d got=%b exp=%b", cyc, {reset_req, busy, cause},
                     exp_out());
         end
      end
      n_cmp++;
      if (cause !== 3'b010) begin
         n_bad++;
         $display("FAIL clr_vs_capture got=%b exp=010", cause);
      end
   endtask

   task automatic test_mid_reset();
      int hi;
      sw_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         sw_req = 1'b0;
         n_cmp++;
         if ({reset_req, busy, cause} !== exp_out()) begin
            n_bad++;
            $display("FAIL mid_pre cyc=%0d got=%b exp=%b", cyc, {reset_req, busy, cause},
                     exp_out());
         end
      end
      reset_n  = 1'b0;
      in_reset = 1'b1;
      #1;
      n_cmp++;
      if ({reset_req, busy, cause} !== 5'b11000) begin
         n_bad++;
         $display("FAIL mid_async got=%b exp=%b", {reset_req, busy, cause}, 5'b11000);
      end
      repeat (2) tick();
      reset_n = 1'b1;
      release_model();
      hi = 0;
      for (int i = 0; i < P + H + 4; i++) begin
         n_cmp++;
         if ({reset_req, busy, cause} !== exp_out()) begin
            n_bad++;
            $display("FAIL mid_seq cyc=%0d got=%b exp=%b", cyc, {reset_req, busy, cause},
                     exp_out());
         end
         hi += int'(reset_req);
         tick();
      end
      n_cmp++;
      if (hi != P) begin
         n_bad++;
         $display("FAIL mid_width got=%0d exp=%0d", hi, P);
      end
      n_cmp++;
      if (cause !== 3'b000) begin
         n_bad++;
         $display("FAIL mid_cause got=%b exp=000", cause);
      end
   endtask

   task automatic test_random();
      int btn_left;
      btn_left = 5;
      for (int i = 0; i < 2500; i++) begin
         sw_req    = ($urandom_range(0, 39) == 0);
         cause_clr = ($urandom_range(0, 24) == 0);
         if (btn_left == 0) begin
            btn_in   = ~btn_in;
            btn_left = $urandom_range(1, 40);
         end
         btn_left--;
         if ($urandom_range(0, 49) == 0) wdt_en = ~wdt_en;
         if (!wdt_en && ($urandom_range(0, 3) == 0)) wdt_load = W'($urandom_range(0, 12));
         wdt_kick = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 399) == 0) begin
            reset_n  = 1'b0;
            in_reset = 1'b1;
            #1;
            n_cmp++;
            if ({reset_req, busy, cause} !== 5'b11000) begin
               n_bad++;
               $display("FAIL rnd_async cyc=%0d got=%b exp=%b", cyc, {reset_req, busy, cause},
                        5'b11000);
            end
            repeat ($urandom_range(1, 3)) tick();
            reset_n = 1'b1;
            release_model();
         end
         tick();
         n_cmp++;
         if ({reset_req, busy, cause} !== exp_out()) begin
            n_bad++;
            $display("FAIL rnd_seq cyc=%0d got=%b exp=%b", cyc, {reset_req, busy, cause},
                     exp_out());
         end
      end
      sw_req    = 1'b0;
      cause_clr = 1'b0;
      btn_in    = 1'b0;
      wdt_en    = 1'b0;
      wdt_kick  = 1'b0;
   endtask

   initial begin
      test_reset();
      test_sw();
      test_btn_glitch();
      test_btn_hold();
      test_wdt();
      test_sw_wdt_same();
      test_cause_clr();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "simulation time limit reached");
   end

endmodule
